// File: rtl/oppm_tx_arbiter.sv
// Round-robin transmit scheduler that shares one OPPM Encoder among NREQ
// packet sources. It loads the winning source's packet, waits for the frame
// to complete, and then holds an inter-frame gap. A watchdog aborts any frame
// that stalls.
module oppm_tx_arbiter #(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned N_PKT      = 8,
   parameter int unsigned GAP_CT     = 16,
   parameter int unsigned TIMEOUT_CT = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*N_PKT-1:0]     req_data,
   output logic [NREQ-1:0]           ack,
   input  logic                      enc_avail,
   output logic                      enc_start,
   output logic [N_PKT-1:0]          enc_data,
   output logic                      busy,
   output logic [$clog2(NREQ)-1:0]   grant_id,
   output logic                      timeout
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned GW = (GAP_CT > 0) ? $clog2(GAP_CT + 1) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CT + 1);

   localparam logic [IW-1:0] LAST_ID  = IW'(NREQ - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CT > 0) ? GAP_CT - 1 : 0);
   localparam logic [TW-1:0] WD_LIMIT = TW'(TIMEOUT_CT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [N_PKT-1:0]  data_q, data_d;
   logic [TW-1:0]     wd_q, wd_d;
   logic [GW-1:0]     gap_q, gap_d;

   logic [N_PKT-1:0]  pkt [NREQ];
   logic [IW-1:0]     win;
   logic [IW-1:0]     cand;
   logic              found;

   for (genvar g = 0; g < NREQ; g++) begin : g_pkt
      assign pkt[g] = req_data[g*N_PKT +: N_PKT];
   end

   // Round-robin pick: first asserted request at or after the pointer, cyclically.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         cand = IW'((32'(ptr_q) + off) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Next-state and output decode; reset masks the pulse outputs immediately.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      data_d    = data_q;
      wd_d      = wd_q;
      gap_d     = gap_q;
      ack       = '0;
      enc_start = 1'b0;
      timeout   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|req && enc_avail) begin
               grant_d = win;
               data_d  = pkt[win];
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            wd_d = '0;
            if (req[grant_q] && enc_avail) begin
               enc_start    = 1'b1;
               ack[grant_q] = 1'b1;
               ptr_d        = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
               state_d      = S_WAIT_BUSY;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_BUSY, S_WAIT_DONE: begin
            if (wd_q == WD_LIMIT) begin
               timeout = 1'b1;
               gap_d   = '0;
               state_d = (GAP_CT == 0) ? S_IDLE : S_GAP;
            end else begin
               wd_d = wd_q + 1'b1;
               if (state_q == S_WAIT_BUSY) begin
                  if (!enc_avail) state_d = S_WAIT_DONE;
               end else if (enc_avail) begin
                  gap_d   = '0;
                  state_d = (GAP_CT == 0) ? S_IDLE : S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) state_d = S_IDLE;
            else                   gap_d   = gap_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (rst) begin
         ack       = '0;
         enc_start = 1'b0;
         timeout   = 1'b0;
      end
   end

   // State, pointer, grant, packet and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         data_q  <= '0;
         wd_q    <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         wd_q    <= wd_d;
         gap_q   <= gap_d;
      end
   end

   assign enc_data = data_q;
   assign grant_id = grant_q;
   assign busy     = (state_q != S_IDLE);

endmodule
